// File: rtl/ecc_pkg.sv
// Shared definitions for the Hamming(12,8) stream checker: status codes,
// codeword bit positions and the parity generator used by the syndrome stage.
package ecc_pkg;

    typedef enum logic [1:0] {
        ECC_OK        = 2'b00,
        ECC_CORR_DATA = 2'b01,
        ECC_CORR_PAR  = 2'b10,
        ECC_UNCORR    = 2'b11
    } ecc_status_t;

    localparam int DATA_W = 8;
    localparam int PAR_W  = 4;
    localparam int SYN_W  = 4;

    // Codeword positions (1-based); element i belongs to p(2^i) or d(i).
    localparam logic [PAR_W-1:0][3:0]  PAR_POS  = {4'd8, 4'd4, 4'd2, 4'd1};
    localparam logic [DATA_W-1:0][3:0] DATA_POS = {4'd12, 4'd11, 4'd10, 4'd9,
                                                   4'd7,  4'd6,  4'd5,  4'd3};

    // Parity bit k covers every data bit whose position has bit k set.
    function automatic logic [PAR_W-1:0] ecc_calc_parity(input logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p;
        p = '0;
        for (int k = 0; k < PAR_W; k++) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (DATA_POS[i][k]) begin
                    p[k] = p[k] ^ d[i];
                end
            end
        end
        return p;
    endfunction

    function automatic logic ecc_is_par_pos(input logic [SYN_W-1:0] syn);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < PAR_W; k++) begin
            if (syn == PAR_POS[k]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational syndrome generator for one received codeword.
// With ECC_SECDED_EN it also flags an overall even-parity mismatch.
module ecc_syndrome_calc
    import ecc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [PAR_W-1:0]  parity,
`ifdef ECC_SECDED_EN
    input  logic              ovp,
    output logic              ovp_mismatch,
`endif
    output logic [SYN_W-1:0]  syndrome
);

    assign syndrome = ecc_calc_parity(data) ^ parity;

`ifdef ECC_SECDED_EN
    // Even parity over all 13 received bits must come out zero.
    assign ovp_mismatch = ^{data, parity, ovp};
`endif

endmodule

// File: rtl/ecc_stream_checker.sv
// Two-stage pipelined Hamming(12,8) checker/corrector with valid/ready on both
// sides, saturating error counters and a sticky uncorrectable flag.
// Optional SECDED mode (extra in_ovp port) is enabled by defining ECC_SECDED_EN.
module ecc_stream_checker
    import ecc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic [3:0]        in_parity,
`ifdef ECC_SECDED_EN
    input  logic              in_ovp,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [3:0]        out_syndrome,
    output logic [1:0]        out_status,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count,
    output logic              uncorr_sticky
);

    logic              s1_adv;
    logic              s2_adv;
    logic              out_fire;

    logic              s1_valid_reg;
    logic [7:0]        s1_data_reg;
    logic [3:0]        s1_syndrome_reg;
    logic [3:0]        syndrome_next;

    logic              out_valid_reg;
    logic [7:0]        out_data_reg;
    logic [3:0]        out_syndrome_reg;
    ecc_status_t       out_status_reg;

    logic [7:0]        flip_mask;
    logic [7:0]        data_next;
    ecc_status_t       status_next;

    logic [CNT_W-1:0]  corr_count_reg;
    logic [CNT_W-1:0]  uncorr_count_reg;
    logic              uncorr_sticky_reg;

`ifdef ECC_SECDED_EN
    logic              ovp_err_next;
    logic              s1_ovp_err_reg;
`endif

    // Handshake: a stage may load whenever the stage after it can take its word.
    assign s2_adv   = !out_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;
    assign out_fire = out_valid_reg && out_ready;

    ecc_syndrome_calc u_syndrome_calc (
        .data         (in_data),
        .parity       (in_parity),
`ifdef ECC_SECDED_EN
        .ovp          (in_ovp),
        .ovp_mismatch (ovp_err_next),
`endif
        .syndrome     (syndrome_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg    <= 1'b0;
            s1_data_reg     <= '0;
            s1_syndrome_reg <= '0;
`ifdef ECC_SECDED_EN
            s1_ovp_err_reg  <= 1'b0;
`endif
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_data_reg     <= in_data;
                s1_syndrome_reg <= syndrome_next;
`ifdef ECC_SECDED_EN
                s1_ovp_err_reg  <= ovp_err_next;
`endif
            end
        end
    end

    // One-hot mask selecting the data bit addressed by the syndrome.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_flip
        assign flip_mask[gi] = (s1_syndrome_reg == DATA_POS[gi]);
    end

    always_comb begin
        status_next = ECC_OK;
        if (s1_syndrome_reg == 4'd0) begin
            status_next = ECC_OK;
`ifdef ECC_SECDED_EN
            if (s1_ovp_err_reg) begin
                status_next = ECC_CORR_PAR;
            end
`endif
        end else if (s1_syndrome_reg >= 4'd13) begin
            status_next = ECC_UNCORR;
        end else if (ecc_is_par_pos(s1_syndrome_reg)) begin
            status_next = ECC_CORR_PAR;
        end else begin
            status_next = ECC_CORR_DATA;
        end
`ifdef ECC_SECDED_EN
        // Nonzero syndrome with matching overall parity means two bits flipped.
        if (s1_syndrome_reg != 4'd0 && !s1_ovp_err_reg) begin
            status_next = ECC_UNCORR;
        end
`endif
        data_next = s1_data_reg;
        if (status_next == ECC_CORR_DATA) begin
            data_next = s1_data_reg ^ flip_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            out_syndrome_reg <= '0;
            out_status_reg   <= ECC_OK;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg     <= data_next;
                out_syndrome_reg <= s1_syndrome_reg;
                out_status_reg   <= status_next;
            end
        end
    end

    // Counters follow completed output transfers; a clear beats a same-cycle count.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            corr_count_reg    <= '0;
            uncorr_count_reg  <= '0;
            uncorr_sticky_reg <= 1'b0;
        end else if (out_fire) begin
            if ((out_status_reg == ECC_CORR_DATA || out_status_reg == ECC_CORR_PAR)
                && corr_count_reg != {CNT_W{1'b1}}) begin
                corr_count_reg <= corr_count_reg + 1'b1;
            end
            if (out_status_reg == ECC_UNCORR) begin
                uncorr_sticky_reg <= 1'b1;
                if (uncorr_count_reg != {CNT_W{1'b1}}) begin
                    uncorr_count_reg <= uncorr_count_reg + 1'b1;
                end
            end
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_data      = out_data_reg;
    assign out_syndrome  = out_syndrome_reg;
    assign out_status    = out_status_reg;
    assign corr_count    = corr_count_reg;
    assign uncorr_count  = uncorr_count_reg;
    assign uncorr_sticky = uncorr_sticky_reg;

endmodule

// File: tb/tb_ecc_stream_checker.sv
// Directed bench for ecc_stream_checker (CNT_W=4 so saturation is reachable).
// Define ECC_SECDED_EN to also exercise the overall-parity port.
module tb_ecc_stream_checker;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [3:0]       in_parity;
`ifdef ECC_SECDED_EN
    logic             in_ovp;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [3:0]       out_syndrome;
    logic [1:0]       out_status;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_count;
    logic [CNT_W-1:0] uncorr_count;
    logic             uncorr_sticky;

    int checks = 0;
    int errors = 0;

    // Backpressure burst: received words and the expected decoded results.
    localparam logic [3:0][7:0] BP_D  = {8'hF0, 8'h0E, 8'hFF, 8'h00};
    localparam logic [3:0][3:0] BP_P  = {4'b0100, 4'b0111, 4'b0011, 4'b0000};
`ifdef ECC_SECDED_EN
    localparam logic [3:0]      BP_O  = 4'b1100;
`endif
    localparam logic [3:0][7:0] BP_ED = {8'hF0, 8'h0F, 8'hFF, 8'h00};
    localparam logic [3:0][3:0] BP_ES = {4'h0, 4'h3, 4'h0, 4'h0};
    localparam logic [3:0][1:0] BP_ET = {2'b00, 2'b01, 2'b00, 2'b00};

    always #5 clk = ~clk;

    ecc_stream_checker #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_parity     (in_parity),
`ifdef ECC_SECDED_EN
        .in_ovp        (in_ovp),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_syndrome  (out_syndrome),
        .out_status    (out_status),
        .cnt_clr       (cnt_clr),
        .corr_count    (corr_count),
        .uncorr_count  (uncorr_count),
        .uncorr_sticky (uncorr_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single word through an empty pipeline; call at posedge+1 with out_ready=1.
    task automatic run_word(input logic [7:0] d, input logic [3:0] p, input logic ovp,
                            input logic [7:0] ed, input logic [3:0] es,
                            input logic [1:0] est, input string tag);
        in_data   = d;
        in_parity = p;
`ifdef ECC_SECDED_EN
        in_ovp    = ovp;
`endif
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, " valid after 1 cycle"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, " valid after 2 cycles"}, 32'(out_valid), 32'd1);
        chk({tag, " data"}, 32'(out_data), 32'(ed));
        chk({tag, " syndrome"}, 32'(out_syndrome), 32'(es));
        chk({tag, " status"}, 32'(out_status), 32'(est));
        $display("word %s in=%02h/%04b ovp=%0b out=%02h syn=%04b status=%02b",
                 tag, d, p, ovp, out_data, out_syndrome, out_status);
        @(posedge clk); #1;
        chk({tag, " valid drops after transfer"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx;
        int rx;
        logic held_v;
        logic saw_stall;
        logic [7:0] held_d;
        logic [3:0] held_s;
        logic [1:0] held_t;

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        in_parity = 4'hF;
`ifdef ECC_SECDED_EN
        in_ovp    = 1'b0;
`endif
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_syndrome", 32'(out_syndrome), 32'd0);
        chk("reset out_status", 32'(out_status), 32'd0);
        chk("reset corr_count", 32'(corr_count), 32'd0);
        chk("reset uncorr_count", 32'(uncorr_count), 32'd0);
        chk("reset uncorr_sticky", 32'(uncorr_sticky), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst      = 1'b0;

        run_word(8'hB3, 4'b1001, 1'b1, 8'hB3, 4'b0000, 2'b00, "clean");
        chk("clean corr_count", 32'(corr_count), 32'd0);
        chk("clean uncorr_count", 32'(uncorr_count), 32'd0);

        run_word(8'hB2, 4'b1001, 1'b1, 8'hB3, 4'b0011, 2'b01, "d0_err");
        chk("d0_err corr_count", 32'(corr_count), 32'd1);

        run_word(8'hB3, 4'b1000, 1'b1, 8'hB3, 4'b0001, 2'b10, "p1_err");
        chk("p1_err corr_count", 32'(corr_count), 32'd2);

        run_word(8'hB3, 4'b0100, 1'b1, 8'hB3, 4'b1101, 2'b11, "syn13");
        chk("syn13 uncorr_count", 32'(uncorr_count), 32'd1);
        chk("syn13 uncorr_sticky", 32'(uncorr_sticky), 32'd1);
        chk("syn13 corr_count", 32'(corr_count), 32'd2);

        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr corr_count", 32'(corr_count), 32'd0);
        chk("clr uncorr_count", 32'(uncorr_count), 32'd0);
        chk("clr uncorr_sticky", 32'(uncorr_sticky), 32'd0);

        // Position-12 data error, all-ones syndrome, and a p8 error.
        run_word(8'h33, 4'b1001, 1'b1, 8'hB3, 4'b1100, 2'b01, "d7_err");
        run_word(8'hB3, 4'b0110, 1'b1, 8'hB3, 4'b1111, 2'b11, "syn15");
        run_word(8'hB3, 4'b0001, 1'b1, 8'hB3, 4'b1000, 2'b10, "p8_err");
        chk("mixed corr_count", 32'(corr_count), 32'd2);
        chk("mixed uncorr_count", 32'(uncorr_count), 32'd1);

        // Clear in the same cycle as a counted transfer.
        in_data   = 8'hB2;
        in_parity = 4'b1001;
`ifdef ECC_SECDED_EN
        in_ovp    = 1'b1;
`endif
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("clr_race out_valid", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_race corr_count", 32'(corr_count), 32'd0);
        chk("clr_race uncorr_count", 32'(uncorr_count), 32'd0);
        chk("clr_race uncorr_sticky", 32'(uncorr_sticky), 32'd0);

        // Four-word burst with out_ready low for cycles 3..5.
        tx = 0;
        rx = 0;
        held_v = 1'b0;
        saw_stall = 1'b0;
        held_d = '0;
        held_s = '0;
        held_t = '0;
        for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (tx < 4) begin
                in_valid  = 1'b1;
                in_data   = BP_D[tx];
                in_parity = BP_P[tx];
`ifdef ECC_SECDED_EN
                in_ovp    = BP_O[tx];
`endif
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held_v) begin
                chk("hold out_valid", 32'(out_valid), 32'd1);
                chk("hold out_data", 32'(out_data), 32'(held_d));
                chk("hold out_syndrome", 32'(out_syndrome), 32'(held_s));
                chk("hold out_status", 32'(out_status), 32'(held_t));
            end
            if (!in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                chk($sformatf("burst%0d data", rx), 32'(out_data), 32'(BP_ED[rx]));
                chk($sformatf("burst%0d syndrome", rx), 32'(out_syndrome), 32'(BP_ES[rx]));
                chk($sformatf("burst%0d status", rx), 32'(out_status), 32'(BP_ET[rx]));
                $display("word burst%0d out=%02h syn=%04b status=%02b",
                         rx, out_data, out_syndrome, out_status);
                rx++;
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_s = out_syndrome;
            held_t = out_status;
            if (in_valid && in_ready) tx++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("burst words received", 32'(rx), 32'd4);
        chk("burst words accepted", 32'(tx), 32'd4);
        chk("burst in_ready dropped", 32'(saw_stall), 32'd1);
        repeat (3) @(negedge clk);
        chk("burst no duplicate", 32'(out_valid), 32'd0);
        chk("burst corr_count", 32'(corr_count), 32'd1);

        // Reset while a word is in S1: it must never appear.
        in_data   = 8'hB2;
        in_parity = 4'b1001;
`ifdef ECC_SECDED_EN
        in_ovp    = 1'b1;
`endif
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("midreset no output %0d", i), 32'(out_valid), 32'd0);
        end
        chk("midreset corr_count", 32'(corr_count), 32'd0);

        // Seventeen corrected words saturate a 4-bit counter at 15.
        @(posedge clk); #1;
        in_data   = 8'hB2;
        in_parity = 4'b1001;
`ifdef ECC_SECDED_EN
        in_ovp    = 1'b1;
`endif
        in_valid  = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("saturate corr_count", 32'(corr_count), 32'd15);
        chk("saturate uncorr_count", 32'(uncorr_count), 32'd0);
        $display("word saturate corr_count=%0d after 17 corrected words", corr_count);

`ifdef ECC_SECDED_EN
        run_word(8'hB2, 4'b1000, 1'b1, 8'hB2, 4'b0010, 2'b11, "secded_double");
        chk("secded uncorr_count", 32'(uncorr_count), 32'd1);
        chk("secded uncorr_sticky", 32'(uncorr_sticky), 32'd1);
        run_word(8'hB3, 4'b1001, 1'b0, 8'hB3, 4'b0000, 2'b10, "secded_ovp_only");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecc_stream_checker.md
Name: ecc_stream_checker

Overview:
- Receive-side, pipelined Hamming(12,8) checker/corrector for a streaming link. It accepts 8-bit data plus 4-bit parity codewords on a valid/ready input and emits corrected data, syndrome and status on a valid/ready output.
- Keeps saturating corrected/uncorrectable error counters and a sticky uncorrectable flag for the status register block.
- Sits downstream of the encoder / channel, replacing the bare combinational decode on the link.

Parameters:
- CNT_W, 16, width of each error counter (range 4..32).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input codeword valid
- in_ready  out  1  checker can accept codeword
- in_data  in  8  received data d7..d0
- in_parity  in  4  received parity {p8,p4,p2,p1}
- out_valid  out  1  output result valid
- out_ready  in  1  downstream accepts result
- out_data  out  8  corrected data
- out_syndrome  out  4  computed syndrome
- out_status  out  2  00 clean, 01 data bit corrected, 10 parity bit error (data untouched), 11 uncorrectable
- cnt_clr  in  1  synchronous clear of counters and sticky flag
- corr_count  out  CNT_W  saturating count of status 01/10 results
- uncorr_count  out  CNT_W  saturating count of status 11 results
- uncorr_sticky  out  1  set on any status 11 result, cleared by cnt_clr/rst

Behaviour:
- Reset is synchronous on clk, active-high. It clears both stage valids, out_valid, out_data, out_syndrome, out_status, both counters and uncorr_sticky to 0.
- Codeword positions are 1..12. Parity bits sit at positions 1, 2, 4 and 8. Data bits d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11 and 12.
- Parity equations:
  - p1 = d0^d1^d3^d4^d6
  - p2 = d0^d2^d3^d5^d6
  - p4 = d1^d2^d3^d7
  - p8 = d4^d5^d6^d7
- Syndrome = recomputed parity XOR in_parity, bit order {s8,s4,s2,s1}.
- Pipeline has two register stages, so latency is exactly 2 cycles with no backpressure.
  - S1 registers the data and the syndrome.
  - S2 applies the correction and registers the outputs.
- Correction rules, by syndrome value:
  - 0: status 00.
  - 1, 2, 4 or 8: status 10, data passed unchanged.
  - 3, 5, 6, 7, 9, 10, 11 or 12: flip the data bit at that position, status 01.
  - 13, 14 or 15: status 11, data passed uncorrected.
- Handshake, full throughput (1 word/cycle):
  - Transfer occurs when valid && ready.
  - S2 advances when !out_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances.
- While out_valid && !out_ready, all outputs hold stable.
- in_* inputs are ignored while in_ready is 0.
- Counters update in the cycle an output transfer completes, not when S2 loads. Each counter saturates at all-ones and never wraps.
- cnt_clr coincident with a counted transfer: the clear wins and the counter reads 0 next cycle.
- Reset mid-stream drops all in-flight words. No output is produced for them.

Optional Feature:
- Macro ECC_SECDED_EN.
- When defined:
  - Adds input in_ovp (1 bit), the overall even parity over all 12 codeword bits.
  - An overall-parity mismatch with syndrome != 0 follows the correction rules above.
  - Overall-parity mismatch with syndrome = 0: status 10.
  - Overall-parity match with syndrome != 0: status 11 (double error), data uncorrected.
  - Syndromes 13..15 remain status 11.
- When undefined: the port is absent and plain SEC behaviour applies.

Decomposition:
- Package ecc_pkg contains:
  - status enum: ECC_OK, ECC_CORR_DATA, ECC_CORR_PAR, ECC_UNCORR
  - position constants for the parity and data bits
  - function ecc_calc_parity(8b) -> 4b
- One combinational sub-module, ecc_syndrome_calc: data and parity in, syndrome out (plus overall-parity mismatch under ECC_SECDED_EN). Instantiated in S1.

Test Plan:
- Clean word: in_data=8'hB3, in_parity=4'b1001, out_ready=1 -> 2 cycles later out_data=8'hB3, syndrome 0000, status 00, counters 0.
- Data error: in_data=8'hB2 (d0 flipped), parity 4'b1001 -> out_data=8'hB3, syndrome 0011, status 01, corr_count=1.
- Parity error: in_data=8'hB3, parity 4'b1000 -> out_data=8'hB3, syndrome 0001, status 10, corr_count increments.
- Uncorrectable word: syndrome forced to 1101 via data 8'hB3, parity 4'b0100 -> status 11, uncorr_sticky=1, uncorr_count=1. A following cnt_clr pulse zeroes both counters and the flag.
- Backpressure: stream 4 words with out_ready low for 3 cycles mid-burst -> in_ready drops, outputs hold stable, all 4 words emerge in order, no loss or duplication.
- Saturation and SECDED:
  - With CNT_W=4, 17 corrected words -> corr_count=15.
  - Under ECC_SECDED_EN, data 8'hB2, parity 4'b1000, in_ovp matching the original word -> syndrome 0010, status 11, data 8'hB2.
